// File: rtl/gpu_shape_rasterizer_pkg.sv
// Shared types for the shape rasterizer: shape codes, FSM states and the
// position of the shape code inside operand1.
package gpu_pkg;

  typedef enum logic [1:0] {
    POINT   = 2'b00,
    FILL    = 2'b01,
    OUTLINE = 2'b10,
    RSVD    = 2'b11
  } ShapeType;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EMIT = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } RasterState;

  localparam int SHAPE_MSB = 15;
  localparam int SHAPE_LSB = 14;

endpackage

// File: rtl/gpu_raster_counter.sv
// Scan position and normalized bounding box of the current primitive.
// Coordinates are compared before they advance, so they never leave [min,max].
module gpu_raster_counter #(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               outline,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] x_r, y_r, xmin_r, xmax_r, ymin_r, ymax_r;
  logic [COORD_W-1:0] x_nx_s, y_nx_s;
  logic               last_s;

  assign last_s = (x_r == xmax_r) && (y_r == ymax_r);

  // Next scan position; outline rows between the top and bottom edge skip the interior.
  always_comb begin
    x_nx_s = x_r;
    y_nx_s = y_r;
    if (last_s) begin
      x_nx_s = x_r;
      y_nx_s = y_r;
    end else if (x_r < xmax_r) begin
      if (outline && (y_r > ymin_r) && (y_r < ymax_r) && (x_r == xmin_r)) begin
        x_nx_s = xmax_r;
      end else begin
        x_nx_s = x_r + COORD_W'(1);
      end
    end else begin
      x_nx_s = xmin_r;
      y_nx_s = y_r + COORD_W'(1);
    end
  end

  // Bounds and position registers: load normalizes corners, step advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r    <= '0;
      y_r    <= '0;
      xmin_r <= '0;
      xmax_r <= '0;
      ymin_r <= '0;
      ymax_r <= '0;
    end else if (load) begin
      xmin_r <= (bx < ax) ? bx : ax;
      xmax_r <= (bx < ax) ? ax : bx;
      ymin_r <= (by < ay) ? by : ay;
      ymax_r <= (by < ay) ? ay : by;
      x_r    <= (bx < ax) ? bx : ax;
      y_r    <= (by < ay) ? by : ay;
    end else if (step) begin
      x_r <= x_nx_s;
      y_r <= y_nx_s;
    end else begin
      x_r <= x_r;
      y_r <= y_r;
    end
  end

  assign x    = x_r;
  assign y    = y_r;
  assign last = last_s;

endmodule

// File: rtl/gpu_shape_rasterizer.sv
// Rasterizes one axis-aligned point / filled rect / rect outline per new_shape,
// handing pixels out one at a time with a data_ready/send_data handshake.
module gpu_shape_rasterizer
  import gpu_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 8,
  parameter int OP_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_shape,
  input  logic [OP_W-1:0]    operand1,
  input  logic [OP_W-1:0]    operand2,
  input  logic [OP_W-1:0]    operand3,
  input  logic               send_data,
  output logic               data_ready,
  output logic               shape_done,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [COLOR_W-1:0] pixel_color
);

  RasterState         state_r, state_nx_s;
  ShapeType           shape_r;
  logic [COLOR_W-1:0] color_r;
  logic [OP_W-1:0]    a_r, b_r, b_eff_s;
  logic               data_ready_r, shape_done_r;
  logic               last_s;
  logic               unused_op1_s;

  assign unused_op1_s = ^operand1[OP_W-3:COLOR_W];

  // Operand capture; a new shape may arrive in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shape_r <= POINT;
      color_r <= '0;
      a_r     <= '0;
      b_r     <= '0;
    end else if (new_shape) begin
      shape_r <= ShapeType'(operand1[SHAPE_MSB:SHAPE_LSB]);
      color_r <= operand1[COLOR_W-1:0];
      a_r     <= operand2;
      b_r     <= operand3;
    end else begin
      shape_r <= shape_r;
      color_r <= color_r;
      a_r     <= a_r;
      b_r     <= b_r;
    end
  end

  // A point collapses the box onto corner A.
  assign b_eff_s = (shape_r == POINT) ? a_r : b_r;

  gpu_raster_counter #(.COORD_W(COORD_W)) u_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (state_r == LOAD),
    .step    (state_r == STEP),
    .outline (shape_r == OUTLINE),
    .ax      (a_r[OP_W-1:COORD_W]),
    .ay      (a_r[COORD_W-1:0]),
    .bx      (b_eff_s[OP_W-1:COORD_W]),
    .by      (b_eff_s[COORD_W-1:0]),
    .x       (pixel_x),
    .y       (pixel_y),
    .last    (last_s)
  );

  // Next-state logic; new_shape overrides everything, including a scan in flight.
  always_comb begin
    state_nx_s = state_r;
    if (new_shape) begin
      state_nx_s = LOAD;
    end else begin
      case (state_r)
        IDLE:    state_nx_s = IDLE;
        LOAD:    state_nx_s = (shape_r == RSVD) ? DONE : EMIT;
        EMIT:    state_nx_s = send_data ? STEP : EMIT;
        STEP:    state_nx_s = last_s ? DONE : EMIT;
        DONE:    state_nx_s = DONE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      data_ready_r <= 1'b0;
      shape_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      data_ready_r <= (state_nx_s == EMIT);
      shape_done_r <= (state_nx_s == DONE);
    end
  end

  assign data_ready  = data_ready_r;
  assign shape_done  = shape_done_r;
  assign pixel_color = color_r;

endmodule

// File: tb/tb_gpu_shape_rasterizer.sv
// Directed bench for gpu_shape_rasterizer: point, fill, outline with
// backpressure, reserved code, abort and asynchronous reset.
module tb_gpu_shape_rasterizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_shape;
  logic [15:0] operand1, operand2, operand3;
  logic        send_data;
  logic        data_ready, shape_done;
  logic [7:0]  pixel_x, pixel_y, pixel_color;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpu_shape_rasterizer dut (
    .clk         (clk),
    .reset       (reset),
    .new_shape   (new_shape),
    .operand1    (operand1),
    .operand2    (operand2),
    .operand3    (operand3),
    .send_data   (send_data),
    .data_ready  (data_ready),
    .shape_done  (shape_done),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_pix(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                         input logic [7:0] ec);
    n_cmp++;
    assert ({pixel_x, pixel_y, pixel_color} === {ex, ey, ec}) else begin
      n_err++;
      $error("FAIL %s: observed (%0d,%0d,%h) expected (%0d,%0d,%h)", tag,
             pixel_x, pixel_y, pixel_color, ex, ey, ec);
    end
  endtask

  task automatic start_shape(input logic [1:0] code, input logic [7:0] col,
                             input logic [7:0] ax, input logic [7:0] ay,
                             input logic [7:0] bx, input logic [7:0] by);
    operand1  = {code, 6'd0, col};
    operand2  = {ax, ay};
    operand3  = {bx, by};
    new_shape = 1'b1;
    tick();
    new_shape = 1'b0;
  endtask

  // Wait (bounded) for a pixel, check it, optionally hold it, then consume it.
  task automatic take_pixel(input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] ec,
                            input int hold, input bit stray);
    for (int i = 0; i < 4 && data_ready !== 1'b1; i++) tick();
    chk_bit("ready", data_ready, 1'b1);
    chk_pix("pixel", ex, ey, ec);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk_bit("hold_ready", data_ready, 1'b1);
      chk_pix("hold_pixel", ex, ey, ec);
    end
    send_data = 1'b1;
    tick();
    if (stray) tick();
    send_data = 1'b0;
    if (!stray) chk_bit("step_ready", data_ready, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    new_shape = 1'b0;
    send_data = 1'b0;
    operand1  = 16'h0000;
    operand2  = 16'h0000;
    operand3  = 16'h0000;
    tick();
    tick();
    chk_bit("rst_ready", data_ready, 1'b0);
    chk_bit("rst_done", shape_done, 1'b0);
    chk_pix("rst_pixel", 8'd0, 8'd0, 8'h00);
    reset = 1'b0;
    tick();

    // POINT: corner B ignored, two-cycle latency
    start_shape(2'b00, 8'h3C, 8'd5, 8'd7, 8'd9, 8'd9);
    chk_bit("pt_lat1", data_ready, 1'b0);
    tick();
    chk_bit("pt_lat2", data_ready, 1'b1);
    take_pixel(8'd5, 8'd7, 8'h3C, 0, 1'b0);
    tick();
    chk_bit("pt_done", shape_done, 1'b1);
    chk_bit("pt_done_rdy", data_ready, 1'b0);

    // FILL 2x3 box, row-major
    start_shape(2'b01, 8'h11, 8'd2, 8'd3, 8'd4, 8'd4);
    chk_bit("fill_done_drop", shape_done, 1'b0);
    take_pixel(8'd2, 8'd3, 8'h11, 0, 1'b0);
    take_pixel(8'd3, 8'd3, 8'h11, 0, 1'b0);
    take_pixel(8'd4, 8'd3, 8'h11, 0, 1'b0);
    take_pixel(8'd2, 8'd4, 8'h11, 0, 1'b0);
    take_pixel(8'd3, 8'd4, 8'h11, 0, 1'b0);
    take_pixel(8'd4, 8'd4, 8'h11, 0, 1'b0);
    tick();
    chk_bit("fill_done", shape_done, 1'b1);

    // OUTLINE with swapped corners, backpressure and stray send_data in STEP
    start_shape(2'b10, 8'hA5, 8'd3, 8'd3, 8'd1, 8'd1);
    take_pixel(8'd1, 8'd1, 8'hA5, 5, 1'b1);
    take_pixel(8'd2, 8'd1, 8'hA5, 5, 1'b1);
    take_pixel(8'd3, 8'd1, 8'hA5, 5, 1'b1);
    take_pixel(8'd1, 8'd2, 8'hA5, 5, 1'b1);
    take_pixel(8'd3, 8'd2, 8'hA5, 5, 1'b1);
    take_pixel(8'd1, 8'd3, 8'hA5, 5, 1'b1);
    take_pixel(8'd2, 8'd3, 8'hA5, 5, 1'b1);
    take_pixel(8'd3, 8'd3, 8'hA5, 5, 1'b1);
    chk_bit("ol_done", shape_done, 1'b1);
    chk_bit("ol_done_rdy", data_ready, 1'b0);
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
    tick();
    chk_bit("ol_stray_done", shape_done, 1'b1);
    chk_bit("ol_stray_rdy", data_ready, 1'b0);

    // Reserved code: no pixels, done two cycles after new_shape
    start_shape(2'b11, 8'hFF, 8'd0, 8'd0, 8'd4, 8'd4);
    chk_bit("rsv_rdy1", data_ready, 1'b0);
    chk_bit("rsv_done1", shape_done, 1'b0);
    tick();
    chk_bit("rsv_rdy2", data_ready, 1'b0);
    chk_bit("rsv_done2", shape_done, 1'b1);
    tick();
    chk_bit("rsv_done3", shape_done, 1'b1);

    // Full-screen FILL aborted mid-scan by a shape at the coordinate maximum
    start_shape(2'b01, 8'h42, 8'd0, 8'd0, 8'd255, 8'd255);
    take_pixel(8'd0, 8'd0, 8'h42, 0, 1'b0);
    take_pixel(8'd1, 8'd0, 8'h42, 0, 1'b0);
    take_pixel(8'd2, 8'd0, 8'h42, 0, 1'b0);
    tick();
    chk_bit("ab_ready", data_ready, 1'b1);
    chk_pix("ab_pixel", 8'd3, 8'd0, 8'h42);
    start_shape(2'b01, 8'h5A, 8'd255, 8'd255, 8'd254, 8'd254);
    chk_bit("ab_drop", data_ready, 1'b0);
    take_pixel(8'd254, 8'd254, 8'h5A, 0, 1'b0);
    take_pixel(8'd255, 8'd254, 8'h5A, 0, 1'b0);
    take_pixel(8'd254, 8'd255, 8'h5A, 0, 1'b0);
    take_pixel(8'd255, 8'd255, 8'h5A, 0, 1'b0);
    tick();
    chk_bit("max_done", shape_done, 1'b1);
    tick();
    tick();
    chk_bit("max_hold", shape_done, 1'b1);
    chk_pix("max_stay", 8'd255, 8'd255, 8'h5A);

    // Asynchronous reset while a pixel is presented
    start_shape(2'b01, 8'h77, 8'd10, 8'd20, 8'd255, 8'd255);
    tick();
    chk_bit("rs_ready", data_ready, 1'b1);
    chk_pix("rs_pixel", 8'd10, 8'd20, 8'h77);
    #2;
    reset = 1'b1;
    #1;
    chk_bit("rs_async_rdy", data_ready, 1'b0);
    chk_bit("rs_async_done", shape_done, 1'b0);
    chk_pix("rs_async_pixel", 8'd0, 8'd0, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk_bit("rs_idle_rdy", data_ready, 1'b0);
    chk_bit("rs_idle_done", shape_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
